// File: rtl/hwpe_ctrl_job_offloader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_job_offloader_pkg
// Brief    : Register map, ACQUIRE response codes and FSM states for the
//            HWPE job offloader.
// Revision : 1.0 - initial release
// ============================================================================
package hwpe_ctrl_job_offloader_pkg;

  localparam int REGFILE_N_MANDATORY_REGS   = 7;
  localparam int REGFILE_N_RESERVED_REGS    = 1;
  localparam int REGFILE_N_MAX_GENERIC_REGS = 8;

  localparam int REG_TRIGGER     = 0;
  localparam int REG_ACQUIRE     = 1;
  localparam int REG_RUNNING_JOB = 4;
  localparam int IO_BASE         = REGFILE_N_MANDATORY_REGS + REGFILE_N_RESERVED_REGS +
                                   REGFILE_N_MAX_GENERIC_REGS;

  localparam logic [31:0] RESP_ANOTHER_PE_OFFLOADING = 32'hFFFF_FFFE;
  localparam logic [31:0] RESP_ALL_CXT_BUSY          = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    OFL_IDLE,
    OFL_ACQ,
    OFL_ACQ_WAIT,
    OFL_BACKOFF,
    OFL_WR,
    OFL_WR_WAIT,
    OFL_TRIG,
    OFL_TRIG_WAIT,
    OFL_POLL_GAP,
    OFL_POLL,
    OFL_POLL_WAIT
  } offloader_state_e;

  // Context field of the address is always zero, so a register is just base + 4*index.
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_ctrl_job_offloader_if.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_job_offloader_if
// Brief    : Peripheral req/gnt/r_valid bus between offloader and HWPE slave.
// Revision : 1.0 - initial release
// ============================================================================
interface hwpe_ctrl_job_offloader_if;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic        r_valid;
  logic [31:0] r_data;

  modport master (output req, add, wen, be, data, input  gnt, r_valid, r_data);
  modport slave  (input  req, add, wen, be, data, output gnt, r_valid, r_data);
endinterface
`default_nettype wire

// File: rtl/hwpe_ctrl_offloader_timer.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_offloader_timer
// Brief    : Loadable down-counter shared by the BACKOFF and POLL_GAP waits.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_offloader_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign expired_o = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/hwpe_ctrl_job_offloader.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_job_offloader
// Brief    : Bus-master FSM that acquires an HWPE context, writes the job's
//            I/O registers, triggers it and polls until it retires.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_job_offloader
  import hwpe_ctrl_job_offloader_pkg::*;
#(
  parameter int          N_IO_REGS      = 2,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          BACKOFF_CYCLES = 16,
  parameter int          POLL_CYCLES    = 8,
  parameter int          MAX_RETRIES    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      job_valid_i,
  output logic                      job_ready_o,
  input  logic [N_IO_REGS*32-1:0]   job_params_i,
  output logic [7:0]                job_id_o,
  output logic                      job_started_o,
  output logic                      job_done_o,
  output logic                      job_abort_o,
  output logic                      busy_o,
  hwpe_ctrl_job_offloader_if.master periph
);
  localparam int          IDX_W        = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;
  localparam int          TMR_W        = 16;
  localparam logic [31:0] ADDR_TRIGGER = reg_addr(BASE_ADDR, 32'(REG_TRIGGER));
  localparam logic [31:0] ADDR_ACQUIRE = reg_addr(BASE_ADDR, 32'(REG_ACQUIRE));
  localparam logic [31:0] ADDR_RUNNING = reg_addr(BASE_ADDR, 32'(REG_RUNNING_JOB));

  offloader_state_e           r_state, w_state_nxt, w_issue_wait;
  logic                       r_req, w_req_nxt, r_wen, w_wen_nxt;
  logic [31:0]                r_add, w_add_nxt, r_data, w_data_nxt;
  logic [IDX_W-1:0]           r_idx, w_idx_nxt;
  logic [7:0]                 r_retry, w_retry_nxt, r_job_id, w_job_id_nxt;
  logic                       r_started, r_done, r_abort;
  logic                       w_started_nxt, w_done_nxt, w_abort_nxt;
  logic [N_IO_REGS-1:0][31:0] r_params;
  logic                       w_capture, w_tmr_load, w_tmr_expired;
  logic [TMR_W-1:0]           w_tmr_val;
  logic                       w_issue, w_issue_wen;
  logic [31:0]                w_issue_add, w_issue_data;
  logic                       w_acq_busy;
  logic [7:0]                 w_retry_inc, w_poll_delta;

  assign w_acq_busy   = (periph.r_data == RESP_ANOTHER_PE_OFFLOADING) ||
                        (periph.r_data == RESP_ALL_CXT_BUSY);
  assign w_retry_inc  = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;
  // Distance of the running job ID past ours; the top half means "not yet", which survives ID wrap.
  assign w_poll_delta = periph.r_data[7:0] - r_job_id - 8'd1;

  hwpe_ctrl_offloader_timer #(.WIDTH(TMR_W)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .expired_o  (w_tmr_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= OFL_IDLE;
      r_req     <= 1'b0;
      r_add     <= '0;
      r_wen     <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
      r_retry   <= '0;
      r_job_id  <= '0;
      r_started <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_params  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_add     <= w_add_nxt;
      r_wen     <= w_wen_nxt;
      r_data    <= w_data_nxt;
      r_idx     <= w_idx_nxt;
      r_retry   <= w_retry_nxt;
      r_job_id  <= w_job_id_nxt;
      r_started <= w_started_nxt;
      r_done    <= w_done_nxt;
      r_abort   <= w_abort_nxt;
      if (w_capture) r_params <= job_params_i;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_add_nxt     = r_add;
    w_wen_nxt     = r_wen;
    w_data_nxt    = r_data;
    w_idx_nxt     = r_idx;
    w_retry_nxt   = r_retry;
    w_job_id_nxt  = r_job_id;
    w_started_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_abort_nxt   = 1'b0;
    w_capture     = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_issue       = 1'b0;
    w_issue_add   = '0;
    w_issue_wen   = 1'b0;
    w_issue_data  = '0;
    w_issue_wait  = OFL_IDLE;

    case (r_state)
      OFL_IDLE: begin
        if (job_valid_i) begin
          w_capture   = 1'b1;
          w_retry_nxt = '0;
          w_state_nxt = OFL_ACQ;
        end
      end
      OFL_ACQ: begin
        w_issue      = 1'b1;
        w_issue_add  = ADDR_ACQUIRE;
        w_issue_wen  = 1'b1;
        w_issue_wait = OFL_ACQ_WAIT;
      end
      OFL_ACQ_WAIT: begin
        if (periph.r_valid) begin
          if (w_acq_busy) begin
            w_retry_nxt = w_retry_inc;
            if (w_retry_inc == 8'(MAX_RETRIES)) begin
              w_abort_nxt = 1'b1;
              w_state_nxt = OFL_IDLE;
            end else begin
              w_tmr_load  = 1'b1;
              w_tmr_val   = TMR_W'(BACKOFF_CYCLES - 1);
              w_state_nxt = OFL_BACKOFF;
            end
          end else begin
            w_job_id_nxt = periph.r_data[7:0];
            w_idx_nxt    = '0;
            w_state_nxt  = OFL_WR;
          end
        end
      end
      OFL_BACKOFF: begin
        if (w_tmr_expired) w_state_nxt = OFL_ACQ;
      end
      OFL_WR: begin
        w_issue      = 1'b1;
        w_issue_add  = reg_addr(BASE_ADDR, 32'(IO_BASE) + 32'(r_idx));
        w_issue_data = r_params[r_idx];
        w_issue_wait = OFL_WR_WAIT;
      end
      OFL_WR_WAIT: begin
        if (periph.r_valid) begin
          if (r_idx == IDX_W'(N_IO_REGS - 1)) begin
            w_state_nxt = OFL_TRIG;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = OFL_WR;
          end
        end
      end
      OFL_TRIG: begin
        w_issue      = 1'b1;
        w_issue_add  = ADDR_TRIGGER;
        w_issue_wait = OFL_TRIG_WAIT;
      end
      OFL_TRIG_WAIT: begin
        if (periph.r_valid) begin
          w_started_nxt = 1'b1;
          w_tmr_load    = 1'b1;
          w_tmr_val     = TMR_W'(POLL_CYCLES - 1);
          w_state_nxt   = OFL_POLL_GAP;
        end
      end
      OFL_POLL_GAP: begin
        if (w_tmr_expired) w_state_nxt = OFL_POLL;
      end
      OFL_POLL: begin
        w_issue      = 1'b1;
        w_issue_add  = ADDR_RUNNING;
        w_issue_wen  = 1'b1;
        w_issue_wait = OFL_POLL_WAIT;
      end
      OFL_POLL_WAIT: begin
        if (periph.r_valid) begin
          if (w_poll_delta < 8'd128) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = OFL_IDLE;
          end else begin
            w_tmr_load  = 1'b1;
            w_tmr_val   = TMR_W'(POLL_CYCLES - 1);
            w_state_nxt = OFL_POLL_GAP;
          end
        end
      end
      default: w_state_nxt = OFL_IDLE;
    endcase

    // Request phase: raise req one cycle after entry, hold everything until granted.
    if (w_issue) begin
      if (!r_req) begin
        w_req_nxt  = 1'b1;
        w_add_nxt  = w_issue_add;
        w_wen_nxt  = w_issue_wen;
        w_data_nxt = w_issue_data;
      end else if (periph.gnt) begin
        w_req_nxt   = 1'b0;
        w_state_nxt = w_issue_wait;
      end
    end
  end

  assign job_ready_o   = (r_state == OFL_IDLE);
  assign busy_o        = (r_state != OFL_IDLE);
  assign job_id_o      = r_job_id;
  assign job_started_o = r_started;
  assign job_done_o    = r_done;
  assign job_abort_o   = r_abort;
  assign periph.req    = r_req;
  assign periph.add    = r_add;
  assign periph.wen    = r_wen;
  assign periph.be     = 4'hF;
  assign periph.data   = r_data;
endmodule
`default_nettype wire
